// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, state codes,
// datapath select codes and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_WB_MEM   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd12;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(18'd0);

  function automatic logic is_mem_state(input logic [3:0] state);
    return (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multi_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control strobes out.
interface multi_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         OP;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic [1:0]         PCSource;
  logic [1:0]         ALUop;
  logic               ALUsrcA;
  logic [1:0]         ALUsrcB;
  logic               RegWrite;
  logic               RegDst;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUop, ALUsrcA, ALUsrcB, RegWrite, RegDst,
           instr_done, illegal_op, state_o
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUop, ALUsrcA, ALUsrcB, RegWrite, RegDst,
           instr_done, illegal_op, state_o
  );
endinterface

// File: rtl/multi_ctrl_out.sv
// Moore output decode: maps the controller state to the datapath control word.
// mem_ready only gates the strobes that complete a memory access.
module multi_ctrl_out
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control word; unreachable codes behave like ILLEGAL
  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default:    ctrl.illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_ctrl.sv
// Multi-cycle MIPS main controller: state register and next-state logic;
// output decode lives in multi_ctrl_out.
module multi_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  multi_ctrl_if.master   bus
);

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_gated_s;

  multi_ctrl_out u_out (
    .state     (state_r),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_s)
  );

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) next_state_s = S_DECODE;
        else               next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (bus.OP)
          OP_R:    next_state_s = S_EXEC_R;
          OP_LW:   next_state_s = S_MEM_ADDR;
          OP_SW:   next_state_s = S_MEM_ADDR;
          OP_BEQ:  next_state_s = S_BRANCH;
          OP_J:    next_state_s = S_JUMP;
          OP_ADDI: next_state_s = S_ADDI_EX;
          default: next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.OP == OP_SW) next_state_s = S_MEM_WR;
        else                 next_state_s = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (bus.mem_ready) next_state_s = S_WB_MEM;
        else               next_state_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (bus.mem_ready) next_state_s = S_FETCH;
        else               next_state_s = S_MEM_WR;
      end
      S_EXEC_R:  next_state_s = S_WB_R;
      S_ADDI_EX: next_state_s = S_ADDI_WB;
      default:   next_state_s = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) state_r <= S_FETCH;
    else      state_r <= next_state_s;
  end

  // Reset forces every strobe low, even while the old state is still held
  always_comb begin
    if (rst) ctrl_gated_s = ctrl_s;
    else     ctrl_gated_s = CTRL_NONE;
  end

  assign bus.PCWrite     = ctrl_gated_s.pc_write;
  assign bus.PCWriteCond = ctrl_gated_s.pc_write_cond;
  assign bus.IorD        = ctrl_gated_s.iord;
  assign bus.MemRead     = ctrl_gated_s.mem_read;
  assign bus.MemWrite    = ctrl_gated_s.mem_write;
  assign bus.IRWrite     = ctrl_gated_s.ir_write;
  assign bus.MemtoReg    = ctrl_gated_s.mem_to_reg;
  assign bus.PCSource    = ctrl_gated_s.pc_source;
  assign bus.ALUop       = ctrl_gated_s.alu_op;
  assign bus.ALUsrcA     = ctrl_gated_s.alu_src_a;
  assign bus.ALUsrcB     = ctrl_gated_s.alu_src_b;
  assign bus.RegWrite    = ctrl_gated_s.reg_write;
  assign bus.RegDst      = ctrl_gated_s.reg_dst;
  assign bus.instr_done  = ctrl_gated_s.instr_done;
  assign bus.illegal_op  = ctrl_gated_s.illegal_op;
  assign bus.state_o     = rst ? STATE_W'(state_r) : {STATE_W{1'b0}};

endmodule
